// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sort/merge pipeline.
// Holds the frame geometry, the stream-stage state encoding and the
// element type used by the sort stages.
package bitonic_pkg;

   localparam int N_ELEM  = 32;
   localparam int RUN_LEN = 16;
   localparam int ELEM_W  = 32;

   // Counter limits, sized to the 5-bit frame counter.
   localparam logic [4:0] RUN_LAST   = 5'd15;
   localparam logic [4:0] FRAME_LAST = 5'd31;

   typedef logic [ELEM_W-1:0] elem_t;

   typedef enum logic [1:0] {LOAD_A, LOAD_B, MERGE, DRAIN} merge_state_t;

endpackage

// File: rtl/bitonic_merge32.sv
// Combinational 32-element bitonic merger.
// Takes a bitonic sequence (ascending then descending) on in_bus and
// produces it sorted ascending on out_bus, element i at bits
// [i*WIDTH +: WIDTH]. Compares are unsigned.
// Ports:
//   in_bus  - packed 32-element bitonic input
//   out_bus - packed 32-element ascending output
module bitonic_merge32
   import bitonic_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [N_ELEM*WIDTH-1:0] in_bus,
   output logic [N_ELEM*WIDTH-1:0] out_bus
);

   logic [WIDTH-1:0] stg [0:5][0:N_ELEM-1];

   genvar s, i;

   for (i = 0; i < N_ELEM; i++) begin : g_io
      assign stg[0][i] = in_bus[i*WIDTH +: WIDTH];
      assign out_bus[i*WIDTH +: WIDTH] = stg[5][i];
   end

   // Five half-cleaner stages with distances 16,8,4,2,1. Every stage
   // sorts in the same direction because each half stays bitonic.
   for (s = 0; s < 5; s++) begin : g_stage
      localparam int D = 16 >> s;
      for (i = 0; i < N_ELEM; i++) begin : g_elem
         if ((i & D) == 0) begin : g_cmp
            assign stg[s+1][i]   = (stg[s][i] <= stg[s][i+D]) ? stg[s][i]   : stg[s][i+D];
            assign stg[s+1][i+D] = (stg[s][i] <= stg[s][i+D]) ? stg[s][i+D] : stg[s][i];
         end
      end
   end

endmodule

// File: rtl/bitonic_merge32_stream.sv
// Streaming wrapper around the 32-element bitonic merger.
// Loads two ascending 16-word runs (A into slots 0..15, B reversed into
// slots 31..16 so the buffer is bitonic), merges in one cycle, then
// drains the 32 merged words smallest first.
// Ports:
//   clk, rst             - clock, async active-high reset
//   flush                - synchronous abort back to LOAD_A
//   in_valid/in_ready/in_data     - input word stream
//   out_valid/out_ready/out_data  - merged word stream
//   out_last             - marks the 32nd output word
//   order_err            - sticky: an input run was not ascending
//   busy                 - block holds a partial or undrained frame
module bitonic_merge32_stream
   import bitonic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = N_ELEM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             order_err,
   output logic             busy
);

   merge_state_t     state, state_nxt;
   logic [4:0]       cnt, cnt_nxt;
   logic             in_fire, out_fire;
   logic [WIDTH-1:0] prev_word;
   logic [WIDTH-1:0] ibuf [0:N-1];
   logic [WIDTH-1:0] obuf [0:N-1];
   logic [N*WIDTH-1:0] in_bus, out_bus;

   // Outputs are decoded from state so an async reset clears them at once.
   assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
   assign out_valid = (state == DRAIN);
   assign out_last  = (state == DRAIN) && (cnt == FRAME_LAST);
   assign out_data  = (state == DRAIN) ? obuf[cnt] : '0;
   assign busy      = !((state == LOAD_A) && (cnt == 5'd0));
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD_A;
         cnt   <= 5'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; flush overrides any handshake in the same cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (flush) begin
         state_nxt = LOAD_A;
         cnt_nxt   = 5'd0;
      end else begin
         case (state)
            LOAD_A: if (in_fire) begin
               if (cnt == RUN_LAST) begin
                  cnt_nxt   = 5'd0;
                  state_nxt = LOAD_B;
               end else begin
                  cnt_nxt = cnt + 5'd1;
               end
            end
            LOAD_B: if (in_fire) begin
               if (cnt == RUN_LAST) state_nxt = MERGE;
               else                 cnt_nxt   = cnt + 5'd1;
            end
            MERGE: begin
               cnt_nxt   = 5'd0;
               state_nxt = DRAIN;
            end
            DRAIN: if (out_fire) begin
               if (cnt == FRAME_LAST) begin
                  cnt_nxt   = 5'd0;
                  state_nxt = LOAD_A;
               end else begin
                  cnt_nxt = cnt + 5'd1;
               end
            end
            default: begin
               state_nxt = LOAD_A;
               cnt_nxt   = 5'd0;
            end
         endcase
      end
   end

   // Frame buffers carry no reset; their contents only matter once loaded.
   always_ff @(posedge clk) begin
      if (in_fire && !flush) begin
         if (state == LOAD_A) ibuf[cnt] <= in_data;
         else                 ibuf[5'd31 - cnt] <= in_data;
      end
      if (state == MERGE) begin
         for (int i = 0; i < N; i++) obuf[i] <= out_bus[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      in_bus = '0;
      for (int i = 0; i < N; i++) in_bus[i*WIDTH +: WIDTH] = ibuf[i];
   end

   bitonic_merge32 #(.WIDTH(WIDTH)) u_merge (
      .in_bus  (in_bus),
      .out_bus (out_bus)
   );

   // Order checker: the first word of each run has no predecessor, and the
   // first beat of a new frame clears any error left from the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         order_err <= 1'b0;
         prev_word <= '0;
      end else if (flush) begin
         order_err <= 1'b0;
      end else if (in_fire) begin
         prev_word <= in_data;
         if ((state == LOAD_A) && (cnt == 5'd0))
            order_err <= 1'b0;
         else if ((cnt != 5'd0) && (in_data < prev_word))
            order_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bitonic_merge32_stream.sv
// Directed self-checking bench for bitonic_merge32_stream.
module tb_bitonic_merge32_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        order_err;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] stim_a [16];
   logic [31:0] stim_b [16];
   logic [31:0] got    [32];
   int          n_got;
   int          last_pos;
   int          last_cnt;
   int          stall_bad;

   bitonic_merge32_stream #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .order_err (order_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drive one beat; in_ready is high in both load states, so it is taken.
   task automatic send_beat(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame();
      for (int i = 0; i < 16; i++) send_beat(stim_a[i]);
      for (int i = 0; i < 16; i++) send_beat(stim_b[i]);
   endtask

   // Collects output transfers into got[]; mode 1 toggles out_ready 1,0,0,1.
   task automatic collect(input int mode);
      logic        stalled;
      logic [31:0] held;
      int          cyc;
      n_got = 0; last_pos = -1; last_cnt = 0; stall_bad = 0;
      stalled = 1'b0; held = '0; cyc = 0;
      while (n_got < 32 && cyc < 600) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (stalled && (!out_valid || out_data !== held)) stall_bad++;
         stalled = 1'b0;
         if (out_valid && out_ready) begin
            got[n_got] = out_data;
            if (out_last) begin last_pos = n_got; last_cnt++; end
            n_got++;
         end else if (out_valid) begin
            stalled = 1'b1;
            held    = out_data;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #12;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
          out_data !== 32'd0 || order_err !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_values: got rdy=%b vld=%b last=%b data=%0d err=%b busy=%b, want 1 0 0 0 0 0",
                  in_ready, out_valid, out_last, out_data, order_err, busy);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_interleave();
      $display("[TB] interleave");
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = 32'(2*i);
         stim_b[i] = 32'(2*i + 1);
      end
      send_frame();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL merge_cycle: got vld=%b rdy=%b, want 0 0", out_valid, in_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL first_latency: got vld=%b data=%0d, want 1 0", out_valid, out_data);
      end
      collect(0);
      for (int i = 0; i < 32; i++) begin
         tests_run++;
         if (got[i] !== 32'(i)) begin
            tests_failed++;
            $display("[TB] FAIL interleave_word%0d: got %0d, want %0d", i, got[i], i);
         end
      end
      tests_run++;
      if (n_got != 32 || last_pos != 31 || last_cnt != 1 || order_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL interleave_frame: got n=%0d lastpos=%0d lastcnt=%0d err=%b, want 32 31 1 0",
                  n_got, last_pos, last_cnt, order_err);
      end
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL interleave_idle: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_duplicates();
      int bad;
      $display("[TB] duplicates");
      for (int i = 0; i < 16; i++) begin stim_a[i] = 32'd7; stim_b[i] = 32'd7; end
      send_frame();
      collect(0);
      bad = 0;
      for (int i = 0; i < 32; i++) if (got[i] !== 32'd7) bad++;
      tests_run++;
      if (n_got != 32 || bad != 0 || order_err !== 1'b0 || last_pos != 31) begin
         tests_failed++;
         $display("[TB] FAIL duplicates: got n=%0d nonseven=%0d err=%b lastpos=%0d, want 32 0 0 31",
                  n_got, bad, order_err, last_pos);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      logic [31:0] exp;
      $display("[TB] backpressure");
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = 32'(100 + i);
         stim_b[i] = 32'(i);
      end
      send_frame();
      collect(1);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         exp = (i < 16) ? 32'(i) : 32'(100 + i - 16);
         if (got[i] !== exp) begin
            bad++;
            $display("[TB] FAIL bp_word%0d: got %0d, want %0d", i, got[i], exp);
         end
      end
      tests_run++;
      if (bad != 0) tests_failed++;
      tests_run++;
      if (stall_bad != 0 || n_got != 32 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_stall: got unstable=%0d n=%0d vld_after=%b, want 0 32 0",
                  stall_bad, n_got, out_valid);
      end
   endtask

   task automatic test_order_err();
      logic [31:0] sum_in, sum_out;
      $display("[TB] order error");
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = (i < 4) ? 32'(i) : (i == 4) ? 32'd9 : (i == 5) ? 32'd3 : 32'(i + 4);
         stim_b[i] = 32'(i);
      end
      sum_in = '0;
      for (int i = 0; i < 16; i++) sum_in = sum_in + stim_a[i] + stim_b[i];
      for (int i = 0; i < 5; i++) send_beat(stim_a[i]);
      tests_run++;
      if (order_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL order_before: got %b, want 0", order_err);
      end
      send_beat(stim_a[5]);
      tests_run++;
      if (order_err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL order_rise: got %b, want 1", order_err);
      end
      for (int i = 6; i < 16; i++) send_beat(stim_a[i]);
      for (int i = 0; i < 16; i++) send_beat(stim_b[i]);
      collect(0);
      sum_out = '0;
      for (int i = 0; i < 32; i++) sum_out = sum_out + got[i];
      tests_run++;
      if (n_got != 32 || sum_out !== sum_in || order_err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL order_drain: got n=%0d sum=%0d err=%b, want 32 %0d 1",
                  n_got, sum_out, order_err, sum_in);
      end
      send_beat(32'd0);
      tests_run++;
      if (order_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL order_clear: got %b, want 0", order_err);
      end
      for (int i = 1; i < 16; i++) send_beat(32'(2*i));
      for (int i = 0; i < 16; i++) send_beat(32'(2*i + 1));
      collect(0);
      tests_run++;
      if (n_got != 32 || got[0] !== 32'd0 || got[17] !== 32'd17 || got[31] !== 32'd31) begin
         tests_failed++;
         $display("[TB] FAIL order_next_frame: got n=%0d w0=%0d w17=%0d w31=%0d, want 32 0 17 31",
                  n_got, got[0], got[17], got[31]);
      end
   endtask

   task automatic test_flush();
      int bad;
      $display("[TB] flush");
      send_beat(32'd50);
      send_beat(32'd40);
      for (int i = 2; i < 16; i++) send_beat(32'(60 + i));
      for (int i = 0; i < 6; i++) send_beat(32'(i));
      tests_run++;
      if (order_err !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL flush_pre: got err=%b busy=%b, want 1 1", order_err, busy);
      end
      flush = 1'b1;
      send_beat(32'hDEAD);
      flush = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || order_err !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flush_state: got rdy=%b busy=%b err=%b vld=%b, want 1 0 0 0",
                  in_ready, busy, order_err, out_valid);
      end
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = 32'(2*i + 1);
         stim_b[i] = 32'(2*i);
      end
      send_frame();
      collect(0);
      bad = 0;
      for (int i = 0; i < 32; i++) if (got[i] !== 32'(i)) bad++;
      tests_run++;
      if (n_got != 32 || bad != 0 || last_pos != 31) begin
         tests_failed++;
         $display("[TB] FAIL flush_frame: got n=%0d wrong=%0d lastpos=%0d, want 32 0 31", n_got, bad, last_pos);
      end
   endtask

   task automatic test_async_reset();
      int bad;
      $display("[TB] async reset");
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = 32'(200 + i);
         stim_b[i] = 32'(300 + i);
      end
      send_frame();
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL areset_pre: got vld=%b, want 1", out_valid);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL areset_now: got vld=%b rdy=%b busy=%b data=%0d last=%b, want 0 1 0 0 0",
                  out_valid, in_ready, busy, out_data, out_last);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         stim_a[i] = 32'(16 + i);
         stim_b[i] = 32'(i);
      end
      send_frame();
      collect(0);
      bad = 0;
      for (int i = 0; i < 32; i++) if (got[i] !== 32'(i)) bad++;
      tests_run++;
      if (n_got != 32 || bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL areset_frame: got n=%0d wrong=%0d, want 32 0", n_got, bad);
      end
   endtask

   initial begin
      test_reset();
      test_interleave();
      test_duplicates();
      test_backpressure();
      test_order_err();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bitonic_merge32_stream.md
Name: bitonic_merge32_stream

Overview:
- Streaming front/back end for the combinational 32-element bitonic merger.
- Accepts two pre-sorted ascending runs of 16 words each on a valid/ready stream.
- Stores run A at slots 0..15 and run B reversed at slots 31..16, which forms the required bitonic sequence. Drives the merger, registers its result, then streams the 32 merged words out in ascending order.
- Sits between the 16-element sort stage and the search/result consumer.

Parameters:
- WIDTH, 32, element width in bits; all compares are unsigned.
- N, 32, elements per frame; fixed at 32 because the merger is fixed-size.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous abort; returns the block to LOAD_A
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input word
- in_data  input  WIDTH  input word; words 0..15 form run A, words 16..31 form run B
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts the output word
- out_data  output  WIDTH  merged word, smallest first
- out_last  output  1  high with the 32nd output word
- order_err  output  1  sticky flag: an input run was not ascending
- busy  output  1  high in any state other than LOAD_A with cnt==0

Behaviour:
- Reset values (asynchronous): state=LOAD_A, cnt=0, in_ready=1, out_valid=0, out_last=0, out_data=0, order_err=0, busy=0. Buffer contents are don't-care.
- An input beat is accepted when in_valid && in_ready. An output beat is transferred when out_valid && out_ready.
- State LOAD_A (in_ready=1):
  - Each accepted beat writes buf[cnt] and increments cnt.
  - When the beat with cnt==15 is accepted: cnt<=0 and state moves to LOAD_B.
- State LOAD_B (in_ready=1):
  - Each accepted beat writes buf[31-cnt].
  - When the beat with cnt==15 is accepted: state moves to MERGE.
- State MERGE (in_ready=0, out_valid=0):
  - Lasts exactly one cycle.
  - Captures the merger output into the output register array.
  - cnt<=0, then state moves to DRAIN.
- State DRAIN (in_ready=0):
  - out_valid=1 and out_data=obuf[cnt].
  - out_last=1 when cnt==31.
  - On each transfer cnt increments. The transfer with cnt==31 moves the block to LOAD_A with cnt=0.
  - While out_ready=0, out_data and out_last hold stable and out_valid stays high.
- Latency: the first output word is valid 2 cycles after the cycle in which the 32nd input beat is accepted.
- Throughput: 32 input cycles + 1 merge cycle + 32 output cycles per frame. There is no overlap between frames because the block has a single buffer.
- in_ready and out_valid are never high together.
- Order check:
  - Within each run, an accepted word that is less than the previous accepted word of the same run sets order_err.
  - The first word of each run is not compared against anything.
  - Equal words are legal.
  - order_err clears on the first accepted beat of the next frame, i.e. LOAD_A with cnt==0.
  - The frame is still merged and drained. The output is then a permutation of the input, but its order is unspecified.
- Flush:
  - Takes effect on the next clock edge from any state: state=LOAD_A, cnt=0, out_valid=0, order_err=0.
  - Flush takes priority over a simultaneous input or output handshake; that beat is discarded.
- Reset mid-frame: all partial input and undrained output is lost, and outputs immediately take their reset values.
- Widths: cnt is 5 bits. The buffer index for run B is 31-cnt, computed in 5 bits with no wrap.

Decomposition:
- Package bitonic_pkg holds:
  - N_ELEM=32 and RUN_LEN=16.
  - typedef enum logic [1:0] {LOAD_A, LOAD_B, MERGE, DRAIN} merge_state_t.
  - Parameterised element type used by the sort stages.
- The one natural sub-module is the existing combinational bitonic_merge32, instantiated once. Its in_bus is the packed input buffer; its out_bus is captured in MERGE.
- The FSM, counter, order checker and buffers stay in this module.

Test Plan:
- Interleave test (WIDTH=32):
  - Stimulus: run A = 0,2,4..30 and run B = 1,3,5..31, out_ready held 1.
  - Required: out_data = 0,1,2..31 on consecutive cycles; out_last only on 31; first out_valid 2 cycles after the last input accept; order_err=0.
- Duplicates:
  - Stimulus: run A all 7 and run B all 7.
  - Required: 32 outputs of 7; order_err=0.
- Backpressure:
  - Stimulus: run A = 100..115 and run B = 0..15; toggle out_ready 1,0,0,1 repeating.
  - Required: out_data stable during stalls; sequence 0..15 then 100..115; exactly 32 transfers.
- Order error:
  - Stimulus: run A with word 5 = 3 after word 4 = 9.
  - Required: order_err rises the cycle after that accept; the frame still drains 32 words; order_err clears on the first beat of the next frame.
- Flush:
  - Stimulus: assert flush during LOAD_B at cnt=6, together with an in_valid beat.
  - Required: that beat is dropped, in_ready=1, and the next 32 beats form a clean frame that sorts correctly.
- Async reset:
  - Stimulus: assert rst mid-DRAIN between clock edges.
  - Required: out_valid drops immediately, in_ready=1, busy=0; a new frame after release sorts correctly.
